// File: rtl/datapath_param_pkg.sv
// Shared definitions for the parameterised multi-cycle datapath: ALU opcodes,
// fetch FSM states and the width/depth derivation helpers.
package datapath_param_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_t;

   // Number of memory beats needed to assemble one 32-bit instruction.
   function automatic int beats_f(input int width);
      return 32 / width;
   endfunction

   function automatic int bytes_f(input int width);
      return width / 8;
   endfunction

   function automatic int aw_f(input int nreg);
      return $clog2(nreg);
   endfunction

endpackage

// File: rtl/datapath_param_if.sv
// Memory-side bus of the datapath: request/ack handshake, address, read and write data.
interface datapath_param_if #(
   parameter int WIDTH = 8
) ();

   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   logic             mem_req;
   logic [WIDTH-1:0] adr;
   logic [WIDTH-1:0] writedata;

   modport master (
      input  mem_rdata,
      input  mem_ack,
      output mem_req,
      output adr,
      output writedata
   );

   modport slave (
      output mem_rdata,
      output mem_ack,
      input  mem_req,
      input  adr,
      input  writedata
   );

endinterface

// File: rtl/datapath_param_fetch_seq.sv
// Instruction fetch sequencer: IDLE -> FETCH -> DONE, beat counter and the
// fetch base address captured at start so later pc updates do not disturb it.
module fetch_seq
   import datapath_param_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_ack,
   input  logic [WIDTH-1:0] i_pc,
   output logic             o_req,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_beat_we,
   output logic [1:0]       o_beat,
   output logic [WIDTH-1:0] o_fetch_adr
);

   localparam int               BEATS     = beats_f(WIDTH);
   localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);
   localparam logic [WIDTH-1:0] STRIDE    = WIDTH'(bytes_f(WIDTH));

   fetch_state_t     r_state;
   logic [WIDTH-1:0] r_base;
   logic [1:0]       r_beat;
   logic             r_req;
   logic             r_busy;
   logic             r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
         r_beat  <= '0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_FETCH;
                  r_base  <= i_pc;
                  r_beat  <= '0;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (i_ack) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == LAST_BEAT) begin
                     r_state <= ST_DONE;
                     r_req   <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_req       = r_req;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_beat      = r_beat;
   assign o_beat_we   = (r_state == ST_FETCH) && i_ack;
   assign o_fetch_adr = r_base + ({{(WIDTH-2){1'b0}}, r_beat} * STRIDE);

endmodule

// File: rtl/datapath_param_regfile.sv
// Register file with two combinational read ports and one write port;
// register 0 is hard-wired to zero by never accepting writes.
module regfile_param
   import datapath_param_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREG  = 8,
   localparam int AW    = aw_f(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_wa,
   input  logic [WIDTH-1:0] i_wd,
   input  logic [AW-1:0]    i_ra1,
   input  logic [AW-1:0]    i_ra2,
   output logic [WIDTH-1:0] o_rd1,
   output logic [WIDTH-1:0] o_rd2
);

   logic [WIDTH-1:0] r_regs [NREG];

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_regs[gi] <= '0;
         end else if (i_we && (i_wa == AW'(gi)) && (gi != 0)) begin
            r_regs[gi] <= i_wd;
         end
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
   assign o_rd1 = r_regs[i_ra1];
   assign o_rd2 = r_regs[i_ra2];

endmodule

// File: rtl/datapath_param.sv
// Multi-cycle datapath with a beat-wise instruction fetcher for WIDTH-bit
// memories, register file, operand muxes, ALU and next-pc selection.
module datapath_param
   import datapath_param_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREG  = 8,
   localparam int AW    = aw_f(NREG),
   localparam int BEATS = beats_f(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   datapath_param_if.master bus,
   input  logic             fetch_start,
   input  logic             alusrca,
   input  logic             memtoreg,
   input  logic             iord,
   input  logic             pcen,
   input  logic             regwrite,
   input  logic             regdst,
   input  logic [1:0]       pcsource,
   input  logic [1:0]       alusrcb,
   input  logic [2:0]       alucont,
   output logic             fetch_busy,
   output logic             fetch_done,
   output logic             zero,
   output logic [31:0]      instr
);

   logic [WIDTH-1:0] r_pc;
   logic [31:0]      r_instr;
   logic [WIDTH-1:0] r_md;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_aluout;

   logic             w_req;
   logic             w_beat_we;
   logic [1:0]       w_beat;
   logic [WIDTH-1:0] w_fetch_adr;
   logic [AW-1:0]    w_ra1;
   logic [AW-1:0]    w_ra2;
   logic [AW-1:0]    w_rd;
   logic [AW-1:0]    w_wa;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;
   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_jtarget;
   logic [WIDTH-1:0] w_srca;
   logic [WIDTH-1:0] w_srcb;
   logic [WIDTH-1:0] w_aluresult;
   logic [WIDTH-1:0] w_nextpc;

   fetch_seq #(
      .WIDTH(WIDTH)
   ) u_fetch_seq (
      .clk        (clk),
      .rst        (rst),
      .i_start    (fetch_start),
      .i_ack      (bus.mem_ack),
      .i_pc       (r_pc),
      .o_req      (w_req),
      .o_busy     (fetch_busy),
      .o_done     (fetch_done),
      .o_beat_we  (w_beat_we),
      .o_beat     (w_beat),
      .o_fetch_adr(w_fetch_adr)
   );

   // Each beat owns one WIDTH-bit lane of the instruction register.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_instr
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_instr[gi*WIDTH +: WIDTH] <= '0;
         end else if (w_beat_we && (w_beat == 2'(gi))) begin
            r_instr[gi*WIDTH +: WIDTH] <= bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc     <= '0;
         r_md     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluout <= '0;
      end else begin
         if (pcen) begin
            r_pc <= w_nextpc;
         end
         r_md     <= bus.mem_rdata;
         r_a      <= w_rd1;
         r_b      <= w_rd2;
         r_aluout <= w_aluresult;
      end
   end

   assign w_ra1 = r_instr[21 +: AW];
   assign w_ra2 = r_instr[16 +: AW];
   assign w_rd  = r_instr[11 +: AW];
   assign w_wa  = regdst ? w_rd : w_ra2;
   assign w_wd  = memtoreg ? r_md : r_aluout;

   regfile_param #(
      .WIDTH(WIDTH),
      .NREG (NREG)
   ) u_regfile (
      .clk  (clk),
      .rst  (rst),
      .i_we (regwrite),
      .i_wa (w_wa),
      .i_wd (w_wd),
      .i_ra1(w_ra1),
      .i_ra2(w_ra2),
      .o_rd1(w_rd1),
      .o_rd2(w_rd2)
   );

   // Narrow datapaths take the immediate and jump target straight from the low instruction bits.
   if (WIDTH == 32) begin : g_wide
      assign w_imm     = {{16{r_instr[15]}}, r_instr[15:0]};
      assign w_jtarget = {r_pc[31:28], r_instr[25:0], 2'b00};
   end else begin : g_narrow
      assign w_imm     = r_instr[WIDTH-1:0];
      assign w_jtarget = {r_instr[WIDTH-3:0], 2'b00};
   end

   assign w_srca = alusrca ? r_a : r_pc;

   always_comb begin
      w_srcb = r_b;
      case (alusrcb)
         2'd0:    w_srcb = r_b;
         2'd1:    w_srcb = {{(WIDTH-1){1'b0}}, 1'b1};
         2'd2:    w_srcb = w_imm;
         default: w_srcb = {w_imm[WIDTH-3:0], 2'b00};
      endcase
   end

   always_comb begin
      w_aluresult = '0;
      case (alucont)
         ALU_ADD: w_aluresult = w_srca + w_srcb;
         ALU_SUB: w_aluresult = w_srca - w_srcb;
         ALU_AND: w_aluresult = w_srca & w_srcb;
         ALU_OR:  w_aluresult = w_srca | w_srcb;
         ALU_SLT: w_aluresult = {{(WIDTH-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
         default: w_aluresult = '0;
      endcase
   end

   always_comb begin
      w_nextpc = '0;
      case (pcsource)
         2'd0:    w_nextpc = w_aluresult;
         2'd1:    w_nextpc = r_aluout;
         2'd2:    w_nextpc = w_jtarget;
         default: w_nextpc = '0;
      endcase
   end

   assign zero          = (w_aluresult == '0);
   assign instr         = r_instr;
   assign bus.mem_req   = w_req;
   assign bus.adr       = w_req ? w_fetch_adr : (iord ? r_aluout : r_pc);
   assign bus.writedata = r_b;

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param: an 8-bit instance for fetch/ALU/regfile/reset
// scenarios and a 16-bit instance for the stalled two-beat fetch.
module tb_datapath_param;
   import datapath_param_pkg::*;

   logic        clk;
   logic        rst;
   logic        alusrca, memtoreg, iord, pcen, regwrite, regdst;
   logic [1:0]  pcsource, alusrcb;
   logic [2:0]  alucont;
   logic        fetch_start8, fetch_busy8, fetch_done8, zero8;
   logic        fetch_start16, fetch_busy16, fetch_done16, zero16;
   logic [31:0] instr8, instr16;

   int n_cmp = 0;
   int n_err = 0;

   datapath_param_if #(.WIDTH(8))  bus8 ();
   datapath_param_if #(.WIDTH(16)) bus16 ();

   datapath_param #(.WIDTH(8), .NREG(8)) u_dut8 (
      .clk(clk), .rst(rst), .bus(bus8), .fetch_start(fetch_start8),
      .alusrca(alusrca), .memtoreg(memtoreg), .iord(iord), .pcen(pcen),
      .regwrite(regwrite), .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
      .alucont(alucont), .fetch_busy(fetch_busy8), .fetch_done(fetch_done8),
      .zero(zero8), .instr(instr8)
   );

   datapath_param #(.WIDTH(16), .NREG(8)) u_dut16 (
      .clk(clk), .rst(rst), .bus(bus16), .fetch_start(fetch_start16),
      .alusrca(alusrca), .memtoreg(memtoreg), .iord(iord), .pcen(pcen),
      .regwrite(regwrite), .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
      .alucont(alucont), .fetch_busy(fetch_busy16), .fetch_done(fetch_done16),
      .zero(zero16), .instr(instr16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("  ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // md <- v, then write md into ra2 (dst=0) or rd (dst=1), then let b reload.
   task automatic load_reg8(input logic [7:0] v, input logic dst);
      bus8.mem_rdata = v;
      tick();
      memtoreg = 1'b1; regdst = dst; regwrite = 1'b1;
      tick();
      regwrite = 1'b0; memtoreg = 1'b0;
      tick();
   endtask

   // pc <- a + b with a = r1 = 0, i.e. pc <- b.
   task automatic pc_from_b();
      alusrca = 1'b1; alusrcb = 2'd0; alucont = ALU_ADD; pcsource = 2'd0; pcen = 1'b1;
      tick();
      pcen = 1'b0;
   endtask

   task automatic alu_op(input string tag, input logic [2:0] op, input logic sa,
                         input logic [1:0] sb, input logic [7:0] exp);
      alucont = op; alusrca = sa; alusrcb = sb; iord = 1'b1;
      #1;
      chk({tag, "_zero"}, 32'(zero8), 32'(exp == 8'h00));
      tick();
      chk(tag, 32'(bus8.adr), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] word;
      rst = 1'b0;
      alusrca = 0; memtoreg = 0; iord = 0; pcen = 0; regwrite = 0; regdst = 0;
      pcsource = 2'd0; alusrcb = 2'd0; alucont = ALU_ADD;
      fetch_start8 = 0; fetch_start16 = 0;
      bus8.mem_rdata = '0;  bus8.mem_ack = 1'b0;
      bus16.mem_rdata = '0; bus16.mem_ack = 1'b0;
      tick(); tick();
      chk("rst_req",   32'(bus8.mem_req), 32'd0);
      chk("rst_busy",  32'(fetch_busy8),  32'd0);
      chk("rst_done",  32'(fetch_done8),  32'd0);
      chk("rst_instr", instr8,            32'd0);
      chk("rst_adr",   32'(bus8.adr),     32'd0);
      chk("rst_wdata", 32'(bus8.writedata), 32'd0);
      #3 rst = 1'b1;

      // pc counts up to 0x10
      alusrca = 0; alusrcb = 2'd1; alucont = ALU_ADD; pcsource = 2'd0; pcen = 1;
      repeat (16) tick();
      pcen = 0;
      #1 chk("pc_0x10", 32'(bus8.adr), 32'h10);

      // four-beat fetch, ack every cycle
      fetch_start8 = 1; tick(); fetch_start8 = 0;
      chk("f8_req",  32'(bus8.mem_req), 32'd1);
      chk("f8_busy", 32'(fetch_busy8),  32'd1);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("f8_adr%0d", b), 32'(bus8.adr), 32'h10 + 32'(b));
         bus8.mem_rdata = 8'(17 * (b + 1)); bus8.mem_ack = 1;
         tick();
      end
      bus8.mem_ack = 0;
      chk("f8_done",     32'(fetch_done8),  32'd1);
      chk("f8_req_off",  32'(bus8.mem_req), 32'd0);
      chk("f8_busy_dn",  32'(fetch_busy8),  32'd1);
      chk("f8_instr",    instr8,            32'h44332211);
      tick();
      chk("f8_done_1cy", 32'(fetch_done8),  32'd0);
      chk("f8_idle",     32'(fetch_busy8),  32'd0);

      // ALU checks: instr 0x44332211 -> ra1=1, ra2=3, imm=0x11
      load_reg8(8'hFF, 1'b0);
      chk("b_ff", 32'(bus8.writedata), 32'hFF);
      pc_from_b();
      iord = 0; #1 chk("pc_ff", 32'(bus8.adr), 32'hFF);
      alu_op("add_wrap", ALU_ADD, 1'b0, 2'd1, 8'h00);
      load_reg8(8'h80, 1'b0);
      pc_from_b();
      alu_op("slt_neg", ALU_SLT, 1'b0, 2'd1, 8'h01);
      alu_op("slt_pos", ALU_SLT, 1'b1, 2'd0, 8'h00);
      load_reg8(8'h05, 1'b0);
      pc_from_b();
      alu_op("sub_eq",   ALU_SUB, 1'b0, 2'd0, 8'h00);
      alu_op("sub_one",  ALU_SUB, 1'b0, 2'd1, 8'h04);
      alu_op("or_imm",   ALU_OR,  1'b0, 2'd2, 8'h15);
      alu_op("and_imm",  ALU_AND, 1'b0, 2'd2, 8'h01);
      alu_op("add_imm",  ALU_ADD, 1'b0, 2'd2, 8'h16);
      alu_op("add_imm4", ALU_ADD, 1'b0, 2'd3, 8'h49);
      alu_op("bad_op",   3'b011,  1'b0, 2'd0, 8'h00);
      alu_op("sub_wrap", ALU_SUB, 1'b1, 2'd1, 8'hFF);
      pcsource = 2'd2; pcen = 1; tick(); pcen = 0; pcsource = 2'd0;
      iord = 0; #1 chk("jtarget", 32'(bus8.adr), 32'h44);

      // fetch from 0x44 while pc is rewritten to 0 after beat 0
      word = 32'h00030001;
      fetch_start8 = 1; tick(); fetch_start8 = 0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("fpc_adr%0d", b), 32'(bus8.adr), 32'h44 + 32'(b));
         bus8.mem_rdata = word[b*8 +: 8]; bus8.mem_ack = 1;
         if (b == 0) begin pcsource = 2'd3; pcen = 1; end
         tick();
      end
      bus8.mem_ack = 0; pcen = 0; pcsource = 2'd0;
      chk("fpc_instr", instr8, 32'h00030001);
      tick();
      chk("fpc_pc", 32'(bus8.adr), 32'h00);

      // register file: instr 0x00030001 -> ra1=0, ra2=3, rd=0
      bus8.mem_rdata = 8'h55; tick();
      memtoreg = 1; regdst = 1; regwrite = 1; tick(); regwrite = 0;
      bus8.mem_rdata = 8'hA5; tick();
      regdst = 0; regwrite = 1; tick();
      regwrite = 0; memtoreg = 0;
      chk("rf_same_cycle_old", 32'(bus8.writedata), 32'h05);
      tick();
      chk("rf_r3", 32'(bus8.writedata), 32'hA5);
      alusrca = 1; alusrcb = 2'd1; alucont = ALU_ADD; iord = 1;
      tick();
      chk("rf_r0_plus1", 32'(bus8.adr), 32'h01);
      iord = 0;

      // reset during a fetch, then restart on the first edge after release
      fetch_start8 = 1; tick(); fetch_start8 = 0;
      bus8.mem_rdata = 8'hAA; bus8.mem_ack = 1; tick(); bus8.mem_ack = 0;
      chk("rst_mid_pre", instr8, 32'h000300AA);
      #2 rst = 0;
      #1;
      chk("rst_mid_req",   32'(bus8.mem_req), 32'd0);
      chk("rst_mid_busy",  32'(fetch_busy8),  32'd0);
      chk("rst_mid_instr", instr8,            32'd0);
      chk("rst_mid_wdata", 32'(bus8.writedata), 32'd0);
      bus8.mem_rdata = 8'h77; bus8.mem_ack = 1; tick(); bus8.mem_ack = 0;
      chk("rst_no_write", instr8, 32'd0);
      fetch_start8 = 1;
      #2 rst = 1;
      tick(); fetch_start8 = 0;
      chk("rst_first_start", 32'(bus8.mem_req), 32'd1);
      word = 32'hEFBEADDE;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("rf2_adr%0d", b), 32'(bus8.adr), 32'(b));
         bus8.mem_rdata = word[b*8 +: 8]; bus8.mem_ack = 1;
         tick();
      end
      bus8.mem_ack = 0;
      chk("rf2_done",  32'(fetch_done8), 32'd1);
      chk("rf2_instr", instr8,           32'hEFBEADDE);
      tick();

      // 16-bit fetch with ack withheld three cycles per beat
      word = 32'hABCD1234;
      fetch_start16 = 1; tick(); fetch_start16 = 0;
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < 3; s++) begin
            chk($sformatf("st_req_b%0d_s%0d", b, s),  32'(bus16.mem_req), 32'd1);
            chk($sformatf("st_adr_b%0d_s%0d", b, s),  32'(bus16.adr),     32'(2 * b));
            chk($sformatf("st_busy_b%0d_s%0d", b, s), 32'(fetch_busy16),  32'd1);
            tick();
         end
         bus16.mem_rdata = word[b*16 +: 16]; bus16.mem_ack = 1;
         tick();
         bus16.mem_ack = 0;
      end
      chk("st_done",  32'(fetch_done16), 32'd1);
      chk("st_busy",  32'(fetch_busy16), 32'd1);
      chk("st_instr", instr16,           32'hABCD1234);
      tick();
      chk("st_idle",  32'(fetch_busy16), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/datapath_param.md
DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/address width; legal values 8, 16, 32.
REQ-002 SHALL have parameter NREG, default 8, register-file depth; power of two, 2..32; AW = log2(NREG).
REQ-003 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_rdata  in  WIDTH  memory read data.
- mem_ack  in  1  memory beat accepted.
- fetch_start  in  1  start instruction fetch.
- alusrca, memtoreg, iord, pcen, regwrite, regdst  in  1 each  controller selects/enables.
- pcsource, alusrcb  in  2 each  mux selects.
- alucont  in  3  ALU operation.
- mem_req  out  1  memory request.
- fetch_busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle fetch-complete pulse.
- zero  out  1  ALU result == 0.
- instr  out  32  instruction register.
- adr  out  WIDTH  memory address.
- writedata  out  WIDTH  B register.

Function
REQ-004 SHALL fetch a 32-bit instruction in BEATS = 32/WIDTH beats using FSM IDLE -> FETCH -> DONE -> IDLE.
REQ-005 IDLE: fetch_start=1 SHALL latch pc into fetch_base, clear beat counter, enter FETCH; fetch_start SHALL be ignored in FETCH and DONE.
REQ-006 FETCH: mem_req SHALL be 1 and adr SHALL equal fetch_base + beat*(WIDTH/8), modulo 2^WIDTH, regardless of iord.
REQ-007 FETCH with mem_ack=1: mem_rdata SHALL be written to instr[beat*WIDTH +: WIDTH] and beat SHALL increment; mem_ack=0 SHALL hold state, with no timeout.
REQ-008 The last beat's ack SHALL move FETCH to DONE; DONE SHALL assert fetch_done for exactly one cycle, then return to IDLE.
REQ-009 fetch_busy SHALL be 1 in FETCH and DONE; mem_req SHALL be 0 outside FETCH.
REQ-010 Outside FETCH, adr SHALL be pc when iord=0 and aluout when iord=1.
REQ-011 pcen SHALL update pc in any state; an in-progress fetch SHALL keep using fetch_base.
REQ-012 Registers md, a, b and aluout SHALL load every cycle from mem_rdata, rd1, rd2 and aluresult respectively.
REQ-013 Register addresses SHALL be ra1=instr[21+:AW], ra2=instr[16+:AW] and rd=instr[11+:AW]; the write address SHALL be ra2 when regdst=0 and rd when regdst=1.
REQ-014 Register 0 SHALL read as 0, and writes to it SHALL be discarded.
REQ-015 A register write SHALL occur at the clock edge when regwrite=1, using wd = aluout if memtoreg=0, else md; a same-cycle read of that register SHALL return the old value.
REQ-016 srca SHALL be pc when alusrca=0 and a when alusrca=1.
REQ-017 srcb SHALL be selected by alusrcb: 0 = b, 1 = constant 1, 2 = imm, 3 = imm<<2 truncated to WIDTH.
REQ-018 imm SHALL be instr[WIDTH-1:0] for WIDTH <= 16, and sign-extended instr[15:0] for WIDTH = 32.
REQ-019 nextpc SHALL be selected by pcsource: 0 = aluresult, 1 = aluout, 2 = jtarget, 3 = 0.
REQ-020 jtarget SHALL be {instr[WIDTH-3:0], 2'b00} for WIDTH <= 16, and {pc[31:28], instr[25:0], 2'b00} for WIDTH = 32.
REQ-021 The ALU SHALL implement 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 1 or 0); other codes SHALL yield 0.
REQ-022 Add and sub SHALL wrap modulo 2^WIDTH.
REQ-023 zero SHALL be combinational from aluresult.

Reset
REQ-024 rst=0 SHALL asynchronously clear pc, fetch_base, beat counter, instr, md, a, b, aluout and all registers, and set the FSM to IDLE.
REQ-025 During reset mem_req, fetch_busy and fetch_done SHALL be 0; a reset during FETCH SHALL abort the fetch with no further instr writes.
REQ-026 The first fetch_start after reset release SHALL be honoured on the first rising edge with rst=1.

Structure
REQ-027 A shared package SHALL hold the alucont encodings, the FSM state enum, and BEATS/AW derivation functions.
REQ-028 The FSM and beat counter SHALL be a sub-module fetch_seq; the register file SHALL be a sub-module regfile_param; the remainder SHALL be flat.

Verification
REQ-029 Fetch, WIDTH=8: pc=0x10, fetch_start, acks every cycle with data 0x11, 0x22, 0x33, 0x44 -> adr 0x10..0x13, instr=0x44332211, fetch_done one cycle after the 4th ack.
REQ-030 Stall, WIDTH=16: ack withheld 3 cycles between beats -> mem_req held, adr stable, instr correct, fetch_busy=1 throughout.
REQ-031 Reset mid-fetch after beat 1 -> mem_req=0 immediately, instr=0, FSM IDLE; a following fetch completes normally.
REQ-032 Register file: write r0=0x55 and r3=0xA5 -> r0 reads 0 and r3 reads 0xA5 on the next cycle; the same-cycle read returns the old value.
REQ-033 ALU, WIDTH=8: 0xFF+1 -> 0x00 with zero=1; slt of 0x80 vs 0x01 -> 1; sub 5-5 -> zero=1.
REQ-034 pcen during fetch: pc changes after beat 0 -> remaining beat addresses still fetch_base-relative.
